// File: rtl/debounced_updown_counter_pkg.sv
// Shared constants and helpers for the debounced up/down counter.
package counter_pkg;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // The debounce counter only ever reaches cycles-1; the extra bit keeps
    // a single-cycle debounce from collapsing to a zero-width vector.
    function automatic int dcnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    localparam int DEF_DCNT_W = dcnt_width(DEF_DEBOUNCE_CYCLES);

endpackage

// File: rtl/debounced_updown_counter_if.sv
// Button inputs and counter outputs of the debounced up/down counter.
interface debounced_updown_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             btn_up_n;
    logic             btn_dn_n;
    logic [WIDTH-1:0] count;
    logic             up_ev;
    logic             dn_ev;
    logic             wrap;

    modport master (
        output btn_up_n, btn_dn_n,
        input  count, up_ev, dn_ev, wrap
    );

    modport slave (
        input  btn_up_n, btn_dn_n,
        output count, up_ev, dn_ev, wrap
    );

endinterface

// File: rtl/debounced_updown_counter_btn_debounce.sv
// One push button: synchroniser, debouncer and press-edge detector.
// The debounced state is stored at pin polarity, so 1 means released.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_ev
);

    localparam int            DW        = dcnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   stable_q;
    logic                   stable_d1_q;
    logic [DW-1:0]          dcnt_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain; reset looks released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
        end
    end

    // Accept a new level only after it has differed from the stable one for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b1;
            dcnt_q   <= '0;
        end else if (s == stable_q) begin
            dcnt_q   <= '0;
        end else if (dcnt_q == DCNT_LAST) begin
            stable_q <= s;
            dcnt_q   <= '0;
        end else begin
            dcnt_q   <= dcnt_q + 1'b1;
        end
    end

    // Delayed copy of the stable level for press-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d1_q <= 1'b1;
        end else begin
            stable_d1_q <= stable_q;
        end
    end

    assign pressed  = ~stable_q;
    assign press_ev = ~stable_q & stable_d1_q;

endmodule

// File: rtl/debounced_updown_counter.sv
// Up/down counter driven by two debounced active-low push buttons.
// Wraps or saturates at the limits depending on SATURATE.
module debounced_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SATURATE        = CNT_WRAP
)
(
    input  logic                       clk,
    input  logic                       rst,
    debounced_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             up_pressed;
    logic             up_press_ev;
    logic             dn_pressed;
    logic             dn_press_ev;
    logic             up_ev;
    logic             dn_ev;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (bus.btn_up_n),
        .pressed  (up_pressed),
        .press_ev (up_press_ev)
    );

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dn (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (bus.btn_dn_n),
        .pressed  (dn_pressed),
        .press_ev (dn_press_ev)
    );

    // A press edge always coincides with the debounced level being pressed.
    assign up_ev = up_press_ev & up_pressed;
    assign dn_ev = dn_press_ev & dn_pressed;

    // Next count: single events step by one, simultaneous events cancel,
    // and the limits either wrap (flagging it) or hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (up_ev && !dn_ev) begin
            if (count_q == CNT_MAX) begin
                if (SATURATE == CNT_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dn_ev && !up_ev) begin
            if (count_q == '0) begin
                if (SATURATE == CNT_WRAP) begin
                    count_d = CNT_MAX;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register and the one-cycle wrap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.up_ev = up_ev;
    assign bus.dn_ev = dn_ev;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Bench for debounced_updown_counter: one wrapping and one saturating
// instance share the same button stimulus and are checked every cycle
// against a behavioural model, plus directed latency/limit checks.
module tb_debounced_updown_counter;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;
    int cyc;

    int up_seen;
    int dn_seen;
    int wrap_seen_w;
    int wrap_seen_s;

    // Behavioural model: per button a delay line, the accepted level and
    // how long the delayed pin has disagreed with it.
    bit hist_q [2][$];
    bit m_st [2];
    int m_run [2];
    bit m_ev [2];
    int m_cnt_w;
    int m_cnt_s;
    bit m_wrap;

    debounced_updown_counter_if #(.WIDTH(WIDTH)) bus_w ();
    debounced_updown_counter_if #(.WIDTH(WIDTH)) bus_s ();

    debounced_updown_counter #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .SATURATE(0)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    debounced_updown_counter #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .SATURATE(1)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 2; b++) begin
            hist_q[b].delete();
            for (int k = 0; k < SYNC; k++) hist_q[b].push_back(1'b1);
            m_st[b]  = 1'b1;
            m_run[b] = 0;
            m_ev[b]  = 1'b0;
        end
        m_cnt_w = 0;
        m_cnt_s = 0;
        m_wrap  = 1'b0;
    endtask

    // The pin seen by the debouncer at an edge is the one applied SYNC
    // edges earlier; a level is accepted after DEB consecutive disagreements.
    task automatic debStep(input int b, input bit raw);
        bit s;
        bit prev;
        s = hist_q[b][0];
        void'(hist_q[b].pop_front());
        hist_q[b].push_back(raw);
        prev = m_st[b];
        if (s != m_st[b]) begin
            m_run[b]++;
            if (m_run[b] >= DEB) begin
                m_st[b]  = s;
                m_run[b] = 0;
            end
        end else begin
            m_run[b] = 0;
        end
        m_ev[b] = prev && !m_st[b];
    endtask

    task automatic modelStep(input bit raw_up, input bit raw_dn);
        int nxt;
        m_wrap = 1'b0;
        if (m_ev[0] && !m_ev[1]) begin
            nxt     = m_cnt_w + 1;
            m_wrap  = (nxt > MAXV);
            m_cnt_w = nxt % (MAXV + 1);
            if (m_cnt_s < MAXV) m_cnt_s++;
        end else if (m_ev[1] && !m_ev[0]) begin
            nxt     = m_cnt_w - 1;
            m_wrap  = (nxt < 0);
            m_cnt_w = (nxt + MAXV + 1) % (MAXV + 1);
            if (m_cnt_s > 0) m_cnt_s--;
        end
        debStep(0, raw_up);
        debStep(1, raw_dn);
    endtask

    // Drive pins at the falling edge, advance the model at the rising edge,
    // compare both instances at the next falling edge.
    task automatic applyStimulus(input logic up_n, input logic dn_n);
        bus_w.btn_up_n = up_n;
        bus_w.btn_dn_n = dn_n;
        bus_s.btn_up_n = up_n;
        bus_s.btn_dn_n = dn_n;
        @(posedge clk);
        if (rst) modelReset();
        else     modelStep(up_n, dn_n);
        @(negedge clk);
        cyc++;
        checkOutput("cnt_w",  int'(bus_w.count), m_cnt_w);
        checkOutput("cnt_s",  int'(bus_s.count), m_cnt_s);
        checkOutput("upev_w", int'(bus_w.up_ev), int'(m_ev[0]));
        checkOutput("dnev_w", int'(bus_w.dn_ev), int'(m_ev[1]));
        checkOutput("upev_s", int'(bus_s.up_ev), int'(m_ev[0]));
        checkOutput("dnev_s", int'(bus_s.dn_ev), int'(m_ev[1]));
        checkOutput("wrap_w", int'(bus_w.wrap),  int'(m_wrap));
        checkOutput("wrap_s", int'(bus_s.wrap),  0);
        up_seen     += int'(bus_w.up_ev);
        dn_seen     += int'(bus_w.dn_ev);
        wrap_seen_w += int'(bus_w.wrap);
        wrap_seen_s += int'(bus_s.wrap);
    endtask

    task automatic clearTallies();
        up_seen     = 0;
        dn_seen     = 0;
        wrap_seen_w = 0;
        wrap_seen_s = 0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        clearTallies();
    endtask

    task automatic pressButton(input bit is_up, input int n);
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < 8; k++) applyStimulus(is_up ? 1'b0 : 1'b1, is_up ? 1'b1 : 1'b0);
            for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1);
        end
    endtask

    initial begin
        int up_left;
        int dn_left;
        logic up_lvl;
        logic dn_lvl;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b1;
        bus_w.btn_up_n = 1'b1;
        bus_w.btn_dn_n = 1'b1;
        bus_s.btn_up_n = 1'b1;
        bus_s.btn_dn_n = 1'b1;
        modelReset();
        clearTallies();
        @(negedge clk);

        // Reset state.
        resetDut();
        checkOutput("rst_cnt",  int'(bus_w.count), 0);
        checkOutput("rst_upev", int'(bus_w.up_ev), 0);
        checkOutput("rst_wrap", int'(bus_w.wrap),  0);

        // 1: clean press, event latency and count timing.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 5) checkOutput("t1_upev_e5", int'(bus_w.up_ev), 0);
            if (i == 6) begin
                checkOutput("t1_upev_e6", int'(bus_w.up_ev), 1);
                checkOutput("t1_cnt_e6",  int'(bus_w.count), 0);
            end
            if (i == 7) begin
                checkOutput("t1_upev_e7", int'(bus_w.up_ev), 0);
                checkOutput("t1_cnt_e7",  int'(bus_w.count), 1);
            end
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t1_cnt_end", int'(bus_w.count), 1);
        checkOutput("t1_upev_n",  up_seen, 1);

        // 2: glitches of 1..3 cycles are ignored, 4 cycles is accepted.
        resetDut();
        for (int len = 1; len <= 3; len++) begin
            for (int k = 0; k < len; k++) applyStimulus(1'b0, 1'b1);
            for (int k = 0; k < 10; k++)  applyStimulus(1'b1, 1'b1);
        end
        checkOutput("t2_glitch_cnt", int'(bus_w.count), 0);
        checkOutput("t2_glitch_ev",  up_seen, 0);
        for (int k = 0; k < 4; k++)  applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1);
        checkOutput("t2_four_cnt", int'(bus_w.count), 1);

        // 3: wrap at the top and bottom.
        resetDut();
        pressButton(1'b1, 16);
        checkOutput("t3_w_cnt",  int'(bus_w.count), 0);
        checkOutput("t3_w_wrap", wrap_seen_w, 1);
        checkOutput("t3_s_cnt",  int'(bus_s.count), 15);
        pressButton(1'b0, 1);
        checkOutput("t3_w_dn",   int'(bus_w.count), 15);
        checkOutput("t3_w_wrap2", wrap_seen_w, 2);
        checkOutput("t3_s_dn",   int'(bus_s.count), 14);

        // 4: saturation holds at both limits.
        resetDut();
        pressButton(1'b1, 20);
        checkOutput("t4_s_up",   int'(bus_s.count), 15);
        checkOutput("t4_w_up",   int'(bus_w.count), 4);
        pressButton(1'b0, 20);
        checkOutput("t4_s_dn",   int'(bus_s.count), 0);
        checkOutput("t4_w_dn",   int'(bus_w.count), 0);
        checkOutput("t4_s_wrap", wrap_seen_s, 0);
        checkOutput("t4_w_wrap", wrap_seen_w, 2);

        // 5: simultaneous presses cancel.
        resetDut();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (i == 6) begin
                checkOutput("t5_upev", int'(bus_w.up_ev), 1);
                checkOutput("t5_dnev", int'(bus_w.dn_ev), 1);
            end
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t5_cnt_w", int'(bus_w.count), 0);
        checkOutput("t5_cnt_s", int'(bus_s.count), 0);
        checkOutput("t5_wrap",  wrap_seen_w, 0);

        // 6: reset mid-debounce with the button still held.
        resetDut();
        pressButton(1'b1, 1);
        checkOutput("t6_pre_cnt", int'(bus_w.count), 1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
        clearTallies();
        rst = 1'b1;
        #1;
        checkOutput("t6_async_cnt", int'(bus_w.count), 0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_rst_ev", up_seen, 0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (i == 6) checkOutput("t6_upev_e6", int'(bus_w.up_ev), 1);
            if (i == 7) checkOutput("t6_cnt_e7",  int'(bus_w.count), 1);
        end
        checkOutput("t6_ev_once", up_seen, 1);

        // Random pin activity with independent hold times and rare resets.
        resetDut();
        up_left = 0;
        dn_left = 0;
        up_lvl  = 1'b1;
        dn_lvl  = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if (up_left == 0) begin
                up_lvl  = logic'($urandom_range(0, 1));
                up_left = $urandom_range(1, 10);
            end
            if (dn_left == 0) begin
                dn_lvl  = logic'($urandom_range(0, 1));
                dn_left = $urandom_range(1, 10);
            end
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus(up_lvl, dn_lvl);
            up_left--;
            dn_left--;
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
